zet_bus_decoder: RTL and testbench
==================================

Name: zet_bus_decoder

Overview:
- Parametrised address decoder and response multiplexer between the Zet CPU bus and N_SLV slaves (memory controller, VDU, I/O devices).
- Replaces hardwired per-slave chip-select and combinational rd_data/ready muxing with table-driven decode, registered responses, memory/IO space separation, a per-transaction timeout and an error response for unmapped accesses.

Parameters:
- N_SLV, 3, number of slave channels (1..8).
- AW, 20, address width.
- DW, 16, data width.
- SLV_BASE, {20'h00000, 20'h000B7, 20'hB8000}, packed N_SLV*AW bases; slave i at bits [i*AW +: AW].
- SLV_MASK, {20'h00000, 20'hFFFFF, 20'hFF000}, packed compare masks; a 1 bit is compared.
- SLV_IO, 3'b010, bit i=1: slave i decodes I/O space (m_io=1); bit i=0: memory space.
- TO_CYC, 255, maximum WAIT cycles before timeout (8-bit counter).
- ERR_DATA, 16'hFFFF, rd_data returned on an unmapped access or a timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- addr  in  AW  CPU address.
- wr_data  in  DW  CPU write data.
- we  in  1  CPU write strobe.
- byte_m  in  1  byte access.
- m_io  in  1  1=I/O space, 0=memory space.
- mem_op  in  1  CPU transaction request.
- rd_data  out  DW  registered read data to CPU.
- ready  out  1  one-cycle completion pulse to CPU.
- s_cs  out  N_SLV  one-hot slave select.
- s_addr  out  AW  latched address.
- s_wr_data  out  DW  latched write data.
- s_we  out  1  latched we.
- s_byte_m  out  1  latched byte_m.
- s_rd_data  in  N_SLV*DW  packed slave read data.
- s_rdy  in  N_SLV  slave ready.
- err  out  1  one-cycle pulse on an unmapped access or a timeout.
- err_cnt  out  8  saturating error count.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. rd_data=0, ready=0, s_cs=0, s_addr=0, s_wr_data=0, s_we=0, s_byte_m=0, err=0, err_cnt=0, timeout counter=0. rst=0 mid-transaction aborts it; no ready is issued.
- Decode: slave i hits when (addr & MASK_i)==(BASE_i & MASK_i) and m_io==SLV_IO[i]. The lowest hitting index wins. With no hit, the access is unmapped.
- IDLE, mem_op=1, hit: latch addr, wr_data, we and byte_m into the s_* outputs; set s_cs to one-hot of the winning index; clear the counter; go to WAIT.
- IDLE, mem_op=1, no hit: go to RESP with rd_data=ERR_DATA and err=1. s_cs stays 0.
- WAIT: s_cs and the s_* outputs are held stable.
  - s_rdy[sel]=1: capture s_rd_data[sel], drop s_cs, go to RESP.
  - Otherwise the counter increments. When the counter equals TO_CYC: drop s_cs, set rd_data=ERR_DATA, pulse err, go to RESP.
  - s_rdy and timeout in the same cycle: s_rdy wins and no error is flagged.
  - s_rdy on a non-selected channel is ignored.
- RESP: ready=1 for exactly this one cycle; rd_data holds its value until the next capture. Go to HOLD.
- HOLD: wait for mem_op=0, then go to IDLE. This prevents one request being issued twice. mem_op low already in RESP is also accepted, so HOLD can be left after one cycle.
- Latency: a slave ready in the cycle after s_cs rises gives ready 3 cycles after mem_op is sampled (IDLE→WAIT→RESP). Unmapped access: ready 2 cycles after.
- err_cnt: increments on each err pulse and saturates at 8'hFF.
- Writes follow the same flow; rd_data content is don't-care for writes, except ERR_DATA on an error.

Test Plan:
- Memory read addr=20'h12345, m_io=0, slave2 returns 16'hA5A5 with s_rdy one cycle after s_cs → s_cs=3'b100, one ready pulse, rd_data=16'hA5A5, err=0.
- VDU write addr=20'hB8010, we=1, byte_m=1, wr_data=16'h0041 → s_cs=3'b001 (slave0 beats the slave2 catch-all), s_addr=20'hB8010, s_byte_m=1 held until s_rdy.
- I/O read addr=20'h000B7, m_io=1 → s_cs=3'b010. I/O read addr=20'h00060 → no s_cs, rd_data=16'hFFFF, err pulse, err_cnt=1, ready 2 cycles after mem_op.
- Slave2 never asserts s_rdy → exactly TO_CYC=255 cycles in WAIT, then ready with rd_data=16'hFFFF and err=1. s_rdy in cycle 255 itself → normal data, err=0.
- mem_op held high 4 cycles after ready → no second s_cs until mem_op goes low and high again. 300 unmapped accesses → err_cnt=8'hFF.
- rst=0 during WAIT → s_cs=0, ready never pulses, all outputs at reset values next cycle. A new transaction after rst=1 completes normally.

Source files
------------

// File: rtl/zet_bus_decoder.sv
// Zet CPU bus decoder: table-driven slave select, registered response path,
// per-transaction timeout and error response for unmapped accesses.
module zet_bus_decoder #(
    parameter int                  N_SLV    = 3,
    parameter int                  AW       = 20,
    parameter int                  DW       = 16,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {20'h00000, 20'h000B7, 20'hB8000},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {20'h00000, 20'hFFFFF, 20'hFF000},
    parameter logic [N_SLV-1:0]    SLV_IO   = 3'b010,
    parameter int                  TO_CYC   = 255,
    parameter logic [DW-1:0]       ERR_DATA = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                we,
    input  logic                byte_m,
    input  logic                m_io,
    input  logic                mem_op,
    output logic [DW-1:0]       rd_data,
    output logic                ready,
    output logic [N_SLV-1:0]    s_cs,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wr_data,
    output logic                s_we,
    output logic                s_byte_m,
    input  logic [N_SLV*DW-1:0] s_rd_data,
    input  logic [N_SLV-1:0]    s_rdy,
    output logic                err,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    localparam logic [7:0] TO_LIM = 8'(TO_CYC);

    state_t         state_q;
    logic [DW-1:0]  rd_data_q;
    logic           ready_q;
    logic [N_SLV-1:0] s_cs_q;
    logic [AW-1:0]  s_addr_q;
    logic [DW-1:0]  s_wr_data_q;
    logic           s_we_q;
    logic           s_byte_m_q;
    logic           err_q;
    logic [7:0]     err_cnt_q;
    logic [7:0]     cnt_q;
    logic           lo_q;

    logic             hit;
    logic [N_SLV-1:0] hit_oh;
    logic [DW-1:0]    sel_data;
    logic             sel_rdy;
    logic [7:0]       cnt_d;
    logic [7:0]       err_cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    // Scanning from the top index down lets the lowest hitting slave overwrite the others.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (((addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))
                && (m_io == SLV_IO[i])) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Only the selected channel is observed; s_cs_q is one-hot or zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (s_cs_q[i]) sel_data = sel_data | s_rd_data[i*DW +: DW];
        end
        sel_rdy = |(s_rdy & s_cs_q);
    end

    assign cnt_d     = cnt_q + 8'd1;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rd_data_q   <= '0;
            ready_q     <= 1'b0;
            s_cs_q      <= '0;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
            s_we_q      <= 1'b0;
            s_byte_m_q  <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            cnt_q       <= '0;
            lo_q        <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        if (hit) begin
                            s_addr_q    <= addr;
                            s_wr_data_q <= wr_data;
                            s_we_q      <= we;
                            s_byte_m_q  <= byte_m;
                            s_cs_q      <= hit_oh;
                            cnt_q       <= '0;
                            state_q     <= S_WAIT;
                        end else begin
                            rd_data_q <= ERR_DATA;
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                            ready_q   <= 1'b1;
                            state_q   <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (sel_rdy) begin
                        rd_data_q <= sel_data;
                        s_cs_q    <= '0;
                        ready_q   <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (cnt_d == TO_LIM) begin
                        rd_data_q <= ERR_DATA;
                        s_cs_q    <= '0;
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        ready_q   <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    lo_q    <= ~mem_op;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // A request still held high from the finished access must not re-issue.
                    if (!mem_op || lo_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign ready     = ready_q;
    assign s_cs      = s_cs_q;
    assign s_addr    = s_addr_q;
    assign s_wr_data = s_wr_data_q;
    assign s_we      = s_we_q;
    assign s_byte_m  = s_byte_m_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_zet_bus_decoder.sv
// Self-checking bench for zet_bus_decoder: directed scenarios plus random
// transactions compared against a table-lookup reference of the address map.
module tb_zet_bus_decoder;

    localparam int TO_CYC = 255;

    // Address map as a plain table: slave index -> base, mask, I/O space.
    localparam logic [19:0] T_BASE [3] = '{20'hB8000, 20'h000B7, 20'h00000};
    localparam logic [19:0] T_MASK [3] = '{20'hFF000, 20'hFFFFF, 20'h00000};
    localparam logic        T_IO   [3] = '{1'b0, 1'b1, 1'b0};

    logic        clk;
    logic        rst;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        byte_m;
    logic        m_io;
    logic        mem_op;
    logic [15:0] rd_data;
    logic        ready;
    logic [2:0]  s_cs;
    logic [19:0] s_addr;
    logic [15:0] s_wr_data;
    logic        s_we;
    logic        s_byte_m;
    logic [47:0] s_rd_data;
    logic [2:0]  s_rdy;
    logic        err;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err_cnt = 0;

    zet_bus_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_data   (wr_data),
        .we        (we),
        .byte_m    (byte_m),
        .m_io      (m_io),
        .mem_op    (mem_op),
        .rd_data   (rd_data),
        .ready     (ready),
        .s_cs      (s_cs),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_we      (s_we),
        .s_byte_m  (s_byte_m),
        .s_rd_data (s_rd_data),
        .s_rdy     (s_rdy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Lowest table index whose masked address and space match; -1 if unmapped.
    function automatic int ref_sel(input logic [19:0] a, input logic io);
        for (int i = 0; i < 3; i++) begin
            if ((((a ^ T_BASE[i]) & T_MASK[i]) == 20'h0) && (io == T_IO[i])) return i;
        end
        return -1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One CPU transaction. delay = s_cs-high cycle in which the slave answers
    // (1 = first cycle, 0 = never). Latency counts clock edges from driving
    // mem_op up to the edge at which the CPU samples ready high.
    task automatic run_txn(input logic [19:0] a, input logic io, input logic w, input logic bm,
                           input logic [15:0] wd, input int delay, input logic [15:0] data,
                           input int hold);
        int          exp_sel;
        logic [2:0]  exp_cs;
        bit          exp_err;
        int          exp_wait;
        int          exp_lat;
        logic [15:0] exp_rd;
        int          waits;
        int          lat;
        bit          got;
        bit          stable;
        bit          reissue;
        logic [2:0]  cs_seen;
        logic [19:0] sa_seen;
        logic [15:0] swd_seen;
        logic        swe_seen;
        logic        sbm_seen;
        logic [15:0] rd_seen;
        logic        err_seen;

        exp_sel = ref_sel(a, io);
        if (exp_sel < 0) begin
            exp_cs   = 3'b000;
            exp_err  = 1'b1;
            exp_wait = 0;
        end else begin
            exp_cs   = 3'(1 << exp_sel);
            exp_err  = (delay < 1) || (delay > TO_CYC);
            exp_wait = exp_err ? TO_CYC : delay;
        end
        exp_lat = (exp_sel < 0) ? 2 : 2 + exp_wait;
        exp_rd  = exp_err ? 16'hFFFF : data;
        if (exp_err && exp_err_cnt < 255) exp_err_cnt++;

        addr = a; m_io = io; we = w; byte_m = bm; wr_data = wd; mem_op = 1'b1;
        s_rdy = 3'b000;
        waits = 0; lat = 0; got = 0; stable = 1; reissue = 0;
        cs_seen = 3'b000; sa_seen = '0; swd_seen = '0; swe_seen = 0; sbm_seen = 0;
        rd_seen = '0; err_seen = 0;

        for (int c = 1; c <= 400 && !got; c++) begin
            cycle();
            s_rd_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            s_rdy     = 3'($urandom) & ~s_cs;
            if (ready) begin
                got      = 1;
                lat      = c + 1;
                rd_seen  = rd_data;
                err_seen = err;
                s_rdy    = 3'b000;
            end else if (s_cs != 3'b000) begin
                waits++;
                if (waits == 1) begin
                    cs_seen = s_cs; sa_seen = s_addr; swd_seen = s_wr_data;
                    swe_seen = s_we; sbm_seen = s_byte_m;
                end else if (s_cs !== cs_seen || s_addr !== sa_seen || s_wr_data !== swd_seen
                             || s_we !== swe_seen || s_byte_m !== sbm_seen) begin
                    stable = 0;
                end
                if (waits == delay) begin
                    s_rdy = s_rdy | s_cs;
                    for (int i = 0; i < 3; i++) if (s_cs[i]) s_rd_data[i*16 +: 16] = data;
                end
            end
        end

        check("ready_seen", 32'(got), 32'(1));
        check("s_cs", 32'(cs_seen), 32'(exp_cs));
        check("wait_cycles", 32'(waits), 32'(exp_wait));
        check("latency", 32'(lat), 32'(exp_lat));
        check("err_pulse", 32'(err_seen), 32'(exp_err));
        if (!w || exp_err) check("rd_data", 32'(rd_seen), 32'(exp_rd));
        if (exp_sel >= 0) begin
            check("s_addr", 32'(sa_seen), 32'(a));
            check("s_wr_data", 32'(swd_seen), 32'(wd));
            check("s_we", 32'(swe_seen), 32'(w));
            check("s_byte_m", 32'(sbm_seen), 32'(bm));
            check("s_stable", 32'(stable), 32'(1));
        end

        cycle();
        check("ready_one_cycle", 32'({ready, err}), 32'(0));
        for (int h = 0; h < hold; h++) begin
            cycle();
            if (s_cs != 3'b000 || ready) reissue = 1;
        end
        check("no_reissue", 32'(reissue), 32'(0));
        mem_op = 1'b0;
        cycle();
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    endtask

    initial begin
        rst = 1'b0; addr = '0; wr_data = '0; we = 0; byte_m = 0; m_io = 0; mem_op = 0;
        s_rd_data = '0; s_rdy = '0;
        repeat (3) cycle();
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_s_cs", 32'(s_cs), 32'(0));
        check("rst_s_addr", 32'(s_addr), 32'(0));
        check("rst_s_wr_data", 32'(s_wr_data), 32'(0));
        check("rst_s_we_bm", 32'({s_we, s_byte_m}), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        rst = 1'b1;
        cycle();

        // Memory read served by the catch-all memory slave.
        run_txn(20'h12345, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'hA5A5, 0);
        // VDU byte write: slave 0 beats the slave 2 catch-all.
        run_txn(20'hB8010, 1'b0, 1'b1, 1'b1, 16'h0041, 3, 16'h0000, 0);
        // Mapped and unmapped I/O reads.
        run_txn(20'h000B7, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 16'h1234, 0);
        run_txn(20'h00060, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'h0000, 0);
        // Silent slave times out; answer in the last allowed cycle is accepted.
        run_txn(20'h12345, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 0);
        run_txn(20'h54321, 1'b0, 1'b0, 1'b0, 16'h0000, TO_CYC, 16'hBEEF, 0);
        // Request held high after ready must not be issued twice.
        run_txn(20'hB8FFE, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'h7E7E, 4);

        // Reset in the middle of WAIT aborts without a ready pulse.
        addr = 20'h12345; m_io = 1'b0; we = 1'b1; byte_m = 1'b1; wr_data = 16'hCAFE; mem_op = 1'b1;
        s_rdy = 3'b000;
        cycle();
        check("abort_s_cs", 32'(s_cs), 32'(3'b100));
        cycle();
        rst = 1'b0; mem_op = 1'b0;
        cycle();
        check("abort_s_cs_clr", 32'(s_cs), 32'(0));
        check("abort_ready", 32'(ready), 32'(0));
        check("abort_rd_data", 32'(rd_data), 32'(0));
        check("abort_s_addr", 32'(s_addr), 32'(0));
        check("abort_s_wr_data", 32'(s_wr_data), 32'(0));
        check("abort_s_we_bm", 32'({s_we, s_byte_m}), 32'(0));
        check("abort_err_cnt", 32'({err, err_cnt}), 32'(0));
        exp_err_cnt = 0;
        rst = 1'b1;
        begin
            bit saw_ready = 0;
            repeat (4) begin
                cycle();
                if (ready) saw_ready = 1;
            end
            check("abort_no_ready", 32'(saw_ready), 32'(0));
        end
        run_txn(20'hB8002, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 16'h5A5A, 0);

        // Random transactions across the address map.
        for (int n = 0; n < 40; n++) begin
            logic [19:0] ra;
            logic [1:0]  region;
            region = 2'($urandom_range(0, 3));
            case (region)
                2'd0:    ra = {8'hB8, 12'($urandom)};
                2'd1:    ra = 20'h000B7;
                2'd2:    ra = 20'($urandom);
                default: ra = {12'h000, 8'($urandom)};
            endcase
            run_txn(ra, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                    $urandom_range(1, 6), 16'($urandom), $urandom_range(0, 3));
        end

        // Enough unmapped accesses to saturate the error counter.
        for (int n = 0; n < 300; n++) begin
            run_txn(20'h00060, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'h0000, 0);
        end
        check("err_cnt_sat", 32'(err_cnt), 32'(8'hFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
